inst_encoder: RTL and testbench
===============================

# inst_encoder

Encodes RV32I instruction descriptors (operation, register indices, 32-bit immediate) into 32-bit machine words. It is the inverse of the control decoder and covers the same instruction subset. The encoder streams words, each tagged with a word address, toward the instruction-memory write port; the boot loader and the test harness use it to build IROM images. It has a one-entry output register with valid/ready handshakes on both sides.

## Interface
- ADDR_W, 14, width of the word address
- BASE_ADDR, 0, first word address after reset or clear
- cpu_clk  in  1  clock; all state updates on the rising edge
- cpu_rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous restart: drop pending word, reset address, error flag and count
- in_valid  in  1  descriptor offered
- in_ready  out  1  descriptor accepted when in_valid & in_ready
- in_op  in  5  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 ADDI, 9 ANDI, 10 ORI, 11 XORI, 12 SLLI, 13 SRLI, 14 SRAI, 15 LW, 16 SW, 17 BEQ, 18 BNE, 19 BLT, 20 BGE, 21 LUI, 22 JAL, 23 JALR; 24–31 undefined
- in_rd / in_rs1 / in_rs2  in  5 each  register indices; unused fields are ignored
- in_imm  in  32  byte-offset or immediate value
- out_valid  out  1  encoded word present
- out_ready  in  1  consumer takes the word when out_valid & out_ready
- out_inst  out  32  encoded instruction
- out_addr  out  ADDR_W  word address of out_inst
- out_err  out  1  the word is a substituted NOP because of an error
- err_sticky  out  1  set by any error word; cleared by reset or clear
- count  out  ADDR_W+1  words emitted; saturates at all-ones

## Operation
- R-type {f7,rs2,rs1,f3,rd,0110011}.
  - f3 values: ADD/SUB 000, SLL 001, XOR 100, SRL/SRA 101, OR 110, AND 111.
  - f7 is 0100000 for SUB and SRA; 0 for all others.
- I-ALU {imm[11:0],rs1,f3,rd,0010011}, with ADDI f3 000, XORI 100, ORI 110, ANDI 111.
- Shifts {f7,imm[4:0],rs1,f3,rd,0010011}, with SLLI f3 001, SRLI/SRAI f3 101. f7 is 0100000 for SRAI only.
- LW {imm[11:0],rs1,010,rd,0000011}.
- JALR {imm[11:0],rs1,000,rd,1100111}.
- SW {imm[11:5],rs2,rs1,010,imm[4:0],0100011}.
- Branches {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],1100011}, with BEQ f3 000, BNE 001, BLT 100, BGE 101.
- LUI {imm[31:12],rd,0110111}.
- JAL {imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111}.
- Error conditions:
  - An undefined in_op is always an error.
  - Range violations are errors only when range checking is compiled in (see Configuration).
- Error word: out_inst = 32'h0000_0013, out_err = 1, err_sticky set. The address still advances and count still increments.
- Address and count:
  - out_addr starts at BASE_ADDR and increments by 1 after each output handshake.
  - It wraps from 2^ADDR_W−1 to 0.
  - count increments on each output handshake.

## Timing
- Reset values: out_valid 0, out_inst 0, out_err 0, out_addr BASE_ADDR, err_sticky 0, count 0.
- Latency: a descriptor accepted in cycle N appears with out_valid = 1 in cycle N+1.
- in_ready = !clear & (!out_valid | out_ready). This path is combinational from out_ready.
- Full throughput: one word per cycle while out_ready = 1.
- While out_valid = 1 and out_ready = 0, out_inst, out_addr and out_err hold stable.
- Simultaneous output and input handshakes: the new word loads with out_addr+1 and out_valid stays 1.
- clear has priority over both handshakes. On the next edge:
  - out_valid and out_err go to 0;
  - out_addr goes to BASE_ADDR;
  - count and err_sticky go to 0.
- An asynchronous reset mid-stall discards the pending word immediately.

## Configuration
- ENC_RANGE_CHECK_EN defined — the following immediates are errors:
  - I / LW / SW / JALR: in_imm[31:11] not all equal.
  - Shifts: in_imm[31:5] ≠ 0.
  - Branches: in_imm[0] ≠ 0, or in_imm[31:12] not all equal.
  - JAL: in_imm[0] ≠ 0, or in_imm[31:20] not all equal.
  - LUI: in_imm[11:0] ≠ 0.
- ENC_RANGE_CHECK_EN undefined: immediates are silently truncated to their fields, and only undefined in_op produces an error.

## Test plan
- Basic encodes, each with out_ready = 1:
  - ADDI rd=1, rs1=0, imm=5 → 0x00500093 at out_addr 0, one cycle after acceptance.
  - SUB rd=3, rs1=1, rs2=2 → 0x402081B3.
  - LUI rd=5, imm=0x12345000 → 0x123452B7.
- Branch and jump immediates:
  - BEQ rs1=1, rs2=2, imm=−8 → 0xFE208CE3.
  - JAL rd=1, imm=2048 → 0x001000EF.
- Range check, ADDI rd=1, rs1=0, imm=2048:
  - With ENC_RANGE_CHECK_EN: 0x00000013, out_err=1, err_sticky=1.
  - Without it: 0x80000093, out_err=0.
- Undefined op: in_op=27 → 0x00000013, out_err=1, address still advances.
- Backpressure and clear:
  - Offer two descriptors with out_ready=0 for 3 cycles: the first word is held stable and in_ready=0.
  - When out_ready=1, the second word is accepted; the two words appear at addresses 0 and 1, and count ends at 2.
  - Assert clear during a stall: out_valid=0 on the next cycle, the next word appears at BASE_ADDR, and count and err_sticky are 0.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I descriptor-to-machine-word encoder with a one-entry output register and address tagging.
// Define ENC_RANGE_CHECK_EN to turn out-of-range immediates into NOP error words.
`timescale 1ns/1ps
module inst_encoder #(
  parameter int ADDR_W    = 14,
  parameter int BASE_ADDR = 0
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       NOP  = 32'h0000_0013;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
    OP_XOR  = 5'd4,  OP_SLL  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7,
    OP_ADDI = 5'd8,  OP_ANDI = 5'd9,  OP_ORI  = 5'd10, OP_XORI = 5'd11,
    OP_SLLI = 5'd12, OP_SRLI = 5'd13, OP_SRAI = 5'd14, OP_LW   = 5'd15,
    OP_SW   = 5'd16, OP_BEQ  = 5'd17, OP_BNE  = 5'd18, OP_BLT  = 5'd19,
    OP_BGE  = 5'd20, OP_LUI  = 5'd21, OP_JAL  = 5'd22, OP_JALR = 5'd23
  } op_e;

  op_e         op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] word;
  logic        undef_op;
  logic        range_err;
  logic        enc_err;
  logic [31:0] enc_inst;
  logic        in_fire;
  logic        out_fire;

  assign op = op_e'(in_op);

  always_comb begin
    f3 = 3'b000;
    case (op)
      OP_SLL, OP_SLLI, OP_BNE:                      f3 = 3'b001;
      OP_LW, OP_SW:                                 f3 = 3'b010;
      OP_XOR, OP_XORI, OP_BLT:                      f3 = 3'b100;
      OP_SRL, OP_SRA, OP_SRLI, OP_SRAI, OP_BGE:     f3 = 3'b101;
      OP_OR, OP_ORI:                                f3 = 3'b110;
      OP_AND, OP_ANDI:                              f3 = 3'b111;
      default:                                      f3 = 3'b000;
    endcase
    f7 = (op == OP_SUB || op == OP_SRA || op == OP_SRAI) ? 7'b0100000 : 7'b0000000;
  end

  // Field packing per format; anything outside the defined subset is flagged here.
  always_comb begin
    word     = '0;
    undef_op = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA:
        word = {f7, in_rs2, in_rs1, f3, in_rd, OPC_R};
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI:
        word = {in_imm[11:0], in_rs1, f3, in_rd, OPC_IMM};
      OP_SLLI, OP_SRLI, OP_SRAI:
        word = {f7, in_imm[4:0], in_rs1, f3, in_rd, OPC_IMM};
      OP_LW:
        word = {in_imm[11:0], in_rs1, f3, in_rd, OPC_LOAD};
      OP_JALR:
        word = {in_imm[11:0], in_rs1, f3, in_rd, OPC_JALR};
      OP_SW:
        word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], OPC_STORE};
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE:
        word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], OPC_BRANCH};
      OP_LUI:
        word = {in_imm[31:12], in_rd, OPC_LUI};
      OP_JAL:
        word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
      default:
        undef_op = 1'b1;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic imm_i_ok;
  logic imm_sh_ok;
  logic imm_b_ok;
  logic imm_j_ok;
  logic imm_u_ok;

  // "All bits equal" is the sign-extension test for each field width.
  assign imm_i_ok  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign imm_sh_ok = ~(|in_imm[31:5]);
  assign imm_b_ok  = ~in_imm[0] & ((&in_imm[31:12]) | ~(|in_imm[31:12]));
  assign imm_j_ok  = ~in_imm[0] & ((&in_imm[31:20]) | ~(|in_imm[31:20]));
  assign imm_u_ok  = ~(|in_imm[11:0]);

  always_comb begin
    range_err = 1'b0;
    case (op)
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW, OP_JALR: range_err = ~imm_i_ok;
      OP_SLLI, OP_SRLI, OP_SRAI:                               range_err = ~imm_sh_ok;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE:                          range_err = ~imm_b_ok;
      OP_JAL:                                                  range_err = ~imm_j_ok;
      OP_LUI:                                                  range_err = ~imm_u_ok;
      default:                                                 range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign enc_err  = undef_op | range_err;
  assign enc_inst = enc_err ? NOP : word;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // out_valid/out_inst/out_addr/out_err never change while out_valid=1 and out_ready=0;
  // in_ready depends combinationally on out_ready so the register refills every cycle.
  assign in_ready = ~clear & (~out_valid | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & ~clear;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      out_valid  <= 1'b0;
      out_inst   <= '0;
      out_err    <= 1'b0;
      out_addr   <= BASE;
      err_sticky <= 1'b0;
      count      <= '0;
    end else if (clear) begin
      out_valid  <= 1'b0;
      out_inst   <= '0;
      out_err    <= 1'b0;
      out_addr   <= BASE;
      err_sticky <= 1'b0;
      count      <= '0;
    end else begin
      if (out_fire) begin
        out_addr <= out_addr + 1'b1;
        if (count != '1) count <= count + 1'b1;
      end
      if (in_fire) begin
        out_valid <= 1'b1;
        out_inst  <= enc_inst;
        out_err   <= enc_err;
        if (enc_err) err_sticky <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomised scoreboard bench for inst_encoder with a field-arithmetic reference encoder.
`timescale 1ns/1ps
module tb_inst_encoder;
  localparam int AW   = 4;
  localparam int BASE = 3;
  localparam int EW   = 33 + AW;
  localparam int CMAX = (1 << (AW + 1)) - 1;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_op;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [31:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [AW-1:0] out_addr;
  logic          out_err;
  logic          err_sticky;
  logic [AW:0]   count;

  inst_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky), .count(count)
  );

  // ---------------- clock ----------------
  always #5 cpu_clk = ~cpu_clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks   = 0;
  int n_fail     = 0;
  int acc_idx    = 0;
  int exp_count  = 0;
  bit exp_sticky = 1'b0;
  int ready_pct  = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: builds each field with shifts and masks from the instruction tables.
  function automatic void ref_encode(input int op, input int rd, input int rs1, input int rs2,
                                     input logic [31:0] imm, output logic [31:0] inst,
                                     output logic err);
    longint u;
    longint w;
    int     s;
    bit     bad;
    bit     undef;
    int     r_f3[8]  = '{0, 0, 7, 6, 4, 1, 5, 5};
    int     i_f3[4]  = '{0, 7, 6, 4};
    int     b_f3[4]  = '{0, 1, 4, 5};
    u = longint'(imm);
    s = $signed(imm);
    w = 0; bad = 0; undef = 0;
    if (op <= 7) begin
      w = (longint'((op == 1 || op == 7) ? 32 : 0) << 25) | (longint'(rs2) << 20) |
          (longint'(rs1) << 15) | (longint'(r_f3[op]) << 12) | (longint'(rd) << 7) | 'h33;
    end else if (op <= 11) begin
      w = ((u & 'hFFF) << 20) | (longint'(rs1) << 15) | (longint'(i_f3[op-8]) << 12) |
          (longint'(rd) << 7) | 'h13;
      bad = (s < -2048) || (s > 2047);
    end else if (op <= 14) begin
      w = (longint'((op == 14) ? 32 : 0) << 25) | ((u & 31) << 20) | (longint'(rs1) << 15) |
          (longint'((op == 12) ? 1 : 5) << 12) | (longint'(rd) << 7) | 'h13;
      bad = (u > 31);
    end else if (op == 15 || op == 23) begin
      w = ((u & 'hFFF) << 20) | (longint'(rs1) << 15) | (longint'((op == 15) ? 2 : 0) << 12) |
          (longint'(rd) << 7) | ((op == 15) ? 'h03 : 'h67);
      bad = (s < -2048) || (s > 2047);
    end else if (op == 16) begin
      w = (((u >> 5) & 127) << 25) | (longint'(rs2) << 20) | (longint'(rs1) << 15) |
          (longint'(2) << 12) | ((u & 31) << 7) | 'h23;
      bad = (s < -2048) || (s > 2047);
    end else if (op <= 20) begin
      w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (longint'(rs2) << 20) |
          (longint'(rs1) << 15) | (longint'(b_f3[op-17]) << 12) | (((u >> 1) & 15) << 8) |
          (((u >> 11) & 1) << 7) | 'h63;
      bad = ((u % 2) != 0) || (s < -4096) || (s > 4095);
    end else if (op == 21) begin
      w = (u & 'hFFFFF000) | (longint'(rd) << 7) | 'h37;
      bad = ((u % 4096) != 0);
    end else if (op == 22) begin
      w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20) |
          (((u >> 12) & 255) << 12) | (longint'(rd) << 7) | 'h6F;
      bad = ((u % 2) != 0) || (s < -(1 << 20)) || (s > (1 << 20) - 1);
    end else begin
      undef = 1;
    end
`ifndef ENC_RANGE_CHECK_EN
    bad = 0;
`endif
    if (undef || bad) begin
      inst = 32'h0000_0013;
      err  = 1'b1;
    end else begin
      inst = w[31:0];
      err  = 1'b0;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(negedge cpu_clk);
    out_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic send(input int op, input int rd, input int rs1, input int rs2, input logic [31:0] imm);
    logic [31:0]   ei;
    logic          ee;
    logic [AW-1:0] ea;
    bit            done;
    done     = 0;
    in_valid = 1'b1;
    in_op    = 5'(op);
    in_rd    = 5'(rd);
    in_rs1   = 5'(rs1);
    in_rs2   = 5'(rs2);
    in_imm   = imm;
    for (int t = 0; t < 200 && !done; t++) begin
      #2;
      if (in_ready) begin
        ref_encode(op, rd, rs1, rs2, imm, ei, ee);
        ea = AW'(BASE + acc_idx);
        exp_q.push_back({ei, ee, ea});
        acc_idx++;
        exp_sticky = exp_sticky | ee;
        done = 1;
      end
      next_cycle();
    end
    in_valid = 1'b0;
    check("send_accepted", 64'(done), 64'd1);
  endtask

  task automatic reset_models();
    exp_q.delete();
    acc_idx    = 0;
    exp_count  = 0;
    exp_sticky = 1'b0;
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    in_valid = 1'b0;
    #2;
    reset_models();
    next_cycle();
    clear = 1'b0;
  endtask

  task automatic reset_pulse();
    in_valid = 1'b0;
    #2;
    cpu_rst = 1'b1;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'd0);
    check("rst_async_addr", 64'(out_addr), 64'(BASE));
    check("rst_async_count", 64'(count), 64'd0);
    reset_models();
    #1;
    cpu_rst = 1'b0;
    next_cycle();
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && exp_q.size() > 0; t++) next_cycle();
    next_cycle();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] held;
    bit            hold;
    hold = 0;
    held = '0;
    forever begin
      @(negedge cpu_clk);
      #1;
      if (cpu_rst) begin
        hold = 0;
      end else begin
        if (hold && out_valid) check("stall_stable", 64'({out_inst, out_err, out_addr}), 64'(held));
        hold = 0;
        check("count", 64'(count), 64'(exp_count));
        check("err_sticky", 64'(err_sticky), 64'(exp_sticky));
        if (!clear && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got inst 0x%08h addr %0d, expected no word", out_inst, out_addr);
          end else begin
            e = exp_q.pop_front();
            check("word_inst_err_addr", 64'({out_inst, out_err, out_addr}), 64'(e));
          end
          if (exp_count < CMAX) exp_count++;
        end else if (!clear && out_valid) begin
          hold = 1;
          held = {out_inst, out_err, out_addr};
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] bnd[15] = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd31, 32'd32,
                             32'd4094, 32'd4095, 32'hFFFF_F000, 32'h0000_1000, 32'h000F_FFFE,
                             32'h0010_0000, 32'd1, 32'd0, 32'hFFF0_0000};
    logic [31:0] imm;
    int          op;
    cpu_rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (2) @(negedge cpu_clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_inst", 64'(out_inst), 64'd0);
    check("rst_err", 64'(out_err), 64'd0);
    check("rst_addr", 64'(out_addr), 64'(BASE));
    check("rst_sticky", 64'(err_sticky), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    #2 cpu_rst = 1'b0;
    next_cycle();

    // Directed encodes with the consumer always ready.
    ready_pct = 100;
    out_ready = 1'b1;
    send(8, 1, 0, 0, 32'd5);
    check("addi_valid_latency", 64'(out_valid), 64'd1);
    check("addi_inst", 64'(out_inst), 64'h0050_0093);
    check("addi_addr", 64'(out_addr), 64'(BASE));
    send(1, 3, 1, 2, 32'd0);
    check("sub_inst", 64'(out_inst), 64'h4020_81B3);
    send(21, 5, 0, 0, 32'h1234_5000);
    check("lui_inst", 64'(out_inst), 64'h1234_52B7);
    send(17, 0, 1, 2, 32'hFFFF_FFF8);
    check("beq_inst", 64'(out_inst), 64'hFE20_8CE3);
    send(22, 1, 0, 0, 32'd2048);
    check("jal_inst", 64'(out_inst), 64'h0010_00EF);
    send(8, 1, 0, 0, 32'd2048);
`ifdef ENC_RANGE_CHECK_EN
    check("addi_range_inst", 64'(out_inst), 64'h0000_0013);
    check("addi_range_err", 64'(out_err), 64'd1);
    check("addi_range_sticky", 64'(err_sticky), 64'd1);
`else
    check("addi_trunc_inst", 64'(out_inst), 64'h8000_0093);
    check("addi_trunc_err", 64'(out_err), 64'd0);
`endif
    send(27, 1, 2, 3, 32'd7);
    check("undef_inst", 64'(out_inst), 64'h0000_0013);
    check("undef_err", 64'(out_err), 64'd1);
    check("undef_addr", 64'(out_addr), 64'((BASE + 6) % (1 << AW)));
    check("undef_sticky", 64'(err_sticky), 64'd1);
    drain();

    // Backpressure: first word held, second descriptor stalled.
    do_clear();
    ready_pct = 0;
    out_ready = 1'b0;
    send(8, 1, 0, 0, 32'd5);
    in_valid = 1'b1; in_op = 5'd1; in_rd = 5'd3; in_rs1 = 5'd1; in_rs2 = 5'd2; in_imm = '0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_inst", 64'(out_inst), 64'h0050_0093);
      next_cycle();
    end
    ready_pct = 100;
    out_ready = 1'b1;
    send(1, 3, 1, 2, 32'd0);
    drain();
    check("bp_count", 64'(count), 64'd2);

    // Clear during a stall discards the pending error word.
    ready_pct = 0;
    out_ready = 1'b0;
    send(30, 0, 0, 0, 32'd0);
    check("pre_clear_sticky", 64'(err_sticky), 64'd1);
    do_clear();
    check("clr_valid", 64'(out_valid), 64'd0);
    check("clr_count", 64'(count), 64'd0);
    check("clr_sticky", 64'(err_sticky), 64'd0);
    ready_pct = 100;
    out_ready = 1'b1;
    send(8, 1, 0, 0, 32'd5);
    check("clr_next_addr", 64'(out_addr), 64'(BASE));
    drain();

    // Asynchronous reset while a word is stalled.
    ready_pct = 0;
    out_ready = 1'b0;
    send(3, 4, 5, 6, 32'd0);
    reset_pulse();
    ready_pct = 100;
    out_ready = 1'b1;
    send(4, 7, 8, 9, 32'd0);
    check("rst_next_addr", 64'(out_addr), 64'(BASE));
    drain();

    // Long unbroken run: address wraps and count saturates.
    do_clear();
    for (int i = 0; i < 40; i++) send($urandom_range(0, 23), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
    drain();
    check("count_saturated", 64'(count), 64'(CMAX));

    // Randomised mix with variable backpressure and occasional clears.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) do_clear();
      if ($urandom_range(0, 19) == 0) ready_pct = $urandom_range(20, 100);
      op = ($urandom_range(0, 9) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23);
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        2:       imm = bnd[$urandom_range(0, 14)];
        default: imm = $urandom & 32'h0000_1FFE;
      endcase
      send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm);
    end
    ready_pct = 100;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
